// File: rtl/flash_axil_pkg.sv
// Shared definitions for the flash AXI4-Lite master: command op codes,
// flash address-encoding bit positions, FSM state encoding and AXI response codes.
package flash_axil_pkg;

  // Command op codes presented on req_op.
  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_ERASE_A = 2'b10,
    OP_ERASE_B = 2'b11
  } op_e;

  // The flash slave decodes the operation from these address bits.
  localparam int ADDR_DATA_BIT    = 24;
  localparam int ADDR_ERASE_A_BIT = 25;
  localparam int ADDR_ERASE_B_BIT = 26;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Master FSM states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_RWAIT,
    S_AW,
    S_BWAIT,
    S_EBUSY,
    S_EDONE,
    S_RSP
  } state_e;

  // Build the 32-bit AXI address: {5'b0, b26, b25, b24, byte_addr}.
  function automatic logic [31:0] encode_addr(input op_e op, input logic [23:0] addr);
    logic [31:0] a;
    a = {8'h00, addr};
    case (op)
      OP_READ, OP_WRITE: a[ADDR_DATA_BIT]    = 1'b1;
      OP_ERASE_A:        a[ADDR_ERASE_A_BIT] = 1'b1;
      default:           a[ADDR_ERASE_B_BIT] = 1'b1;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/flash_timeout_ctr.sv
// Cycle counter shared by the erase busy-wait window and the response timeout.
// 'expired' is high during the limit-th consecutive enabled cycle after a clear,
// so the owner can leave its wait state on that same cycle.
module flash_timeout_ctr #(
  parameter int WIDTH = 20
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Terminal-count compare: count starts at 0 on the first enabled cycle.
  assign expired = enable && (count == (limit - WIDTH'(1)));

  // Count enabled cycles; clear has priority so a new window always starts at 0.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/flash_axil_master.sv
// AXI4-Lite master for the QSPI flash controller slave port.
// Converts a one-outstanding request/response command port into address-encoded
// AXI4-Lite reads, writes and erases. Erase completion is detected from the slave's
// AWREADY busy indication, since the slave never returns a write response for an erase.
module flash_axil_master
  import flash_axil_pkg::*;
#(
  parameter int BUSY_WAIT      = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  // command port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // AXI4-Lite write address
  output logic [31:0] M_AWADDR,
  output logic        M_AWVALID,
  output logic [2:0]  M_AWPROT,
  input  logic        M_AWREADY,
  // AXI4-Lite write data
  output logic [31:0] M_WDATA,
  output logic [3:0]  M_WSTRB,
  output logic        M_WVALID,
  input  logic        M_WREADY,
  // AXI4-Lite write response
  input  logic        M_BVALID,
  input  logic [1:0]  M_BRESP,
  output logic        M_BREADY,
  // AXI4-Lite read address
  output logic [31:0] M_ARADDR,
  output logic        M_ARVALID,
  output logic [2:0]  M_ARPROT,
  input  logic        M_ARREADY,
  // AXI4-Lite read data
  input  logic        M_RVALID,
  input  logic [31:0] M_RDATA,
  input  logic [1:0]  M_RRESP,
  output logic        M_RREADY
);

  // One counter serves both windows, so size it for the larger limit.
  localparam int CTR_MAX = (TIMEOUT_CYCLES > BUSY_WAIT) ? TIMEOUT_CYCLES : BUSY_WAIT;
  localparam int CTR_W   = $clog2(CTR_MAX + 1);

  state_e           state;
  state_e           next_state;
  op_e              op_q;

  logic             req_fire;
  logic             rsp_fire;

  logic             tmo_clear;
  logic             tmo_enable;
  logic             tmo_expired;
  logic [CTR_W-1:0] tmo_limit;

  // Next values of the registered control outputs.
  logic             req_ready_d;
  logic             rsp_valid_d;
  logic             arvalid_d;
  logic             awvalid_d;
  logic             rready_d;
  logic             bready_d;

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // Protection is always unprivileged, secure, data.
  assign M_AWPROT = 3'b000;
  assign M_ARPROT = 3'b000;

  // Counter runs in every wait state; any state change starts a fresh window.
  assign tmo_enable = (state == S_RWAIT) || (state == S_BWAIT) ||
                      (state == S_EBUSY) || (state == S_EDONE);
  assign tmo_clear  = (next_state != state);
  assign tmo_limit  = (state == S_EBUSY) ? CTR_W'(BUSY_WAIT) : CTR_W'(TIMEOUT_CYCLES);

  flash_timeout_ctr #(
    .WIDTH (CTR_W)
  ) u_tmo (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .limit   (tmo_limit),
    .expired (tmo_expired)
  );

  // State register.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples
    // pre-edge values regardless of block evaluation order.
    if (ARESET) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a real response beats an expiring timer in the same cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (req_fire) begin
          next_state = (req_op == OP_READ) ? S_AR : S_AW;
        end
      end
      S_AR: begin
        if (M_ARREADY) begin
          next_state = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (M_RVALID || tmo_expired) begin
          next_state = S_RSP;
        end
      end
      S_AW: begin
        if (M_AWREADY && M_WREADY) begin
          next_state = (op_q == OP_WRITE) ? S_BWAIT : S_EBUSY;
        end
      end
      S_BWAIT: begin
        if (M_BVALID || tmo_expired) begin
          next_state = S_RSP;
        end
      end
      S_EBUSY: begin
        if (!M_AWREADY) begin
          next_state = S_EDONE;
        end else if (tmo_expired) begin
          next_state = S_RSP;
        end
      end
      S_EDONE: begin
        if (M_AWREADY || tmo_expired) begin
          next_state = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_fire) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the registered outputs line up with it.
  always_comb begin
    req_ready_d = (next_state == S_IDLE);
    arvalid_d   = (next_state == S_AR);
    awvalid_d   = (next_state == S_AW);
    rready_d    = (next_state == S_RWAIT);
    bready_d    = (next_state == S_BWAIT);
    rsp_valid_d = (next_state == S_RSP);
  end

  // Control output registers; AWVALID and WVALID share one source so they never split.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      M_ARVALID <= 1'b0;
      M_AWVALID <= 1'b0;
      M_WVALID  <= 1'b0;
      M_RREADY  <= 1'b0;
      M_BREADY  <= 1'b0;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      M_ARVALID <= arvalid_d;
      M_AWVALID <= awvalid_d;
      M_WVALID  <= awvalid_d;
      M_RREADY  <= rready_d;
      M_BREADY  <= bready_d;
    end
  end

  // Command capture and response accumulation; held stable while in AR/AW/RSP.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      op_q      <= OP_READ;
      M_ARADDR  <= '0;
      M_AWADDR  <= '0;
      M_WDATA   <= '0;
      M_WSTRB   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (req_fire) begin
        op_q      <= op_e'(req_op);
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
        if (req_op == OP_READ) begin
          M_ARADDR <= encode_addr(op_e'(req_op), req_addr);
        end else begin
          M_AWADDR <= encode_addr(op_e'(req_op), req_addr);
          M_WDATA  <= (req_op == OP_WRITE) ? req_wdata : 32'h0;
          M_WSTRB  <= (req_op == OP_WRITE) ? 4'hF : 4'h0;
        end
      end
      case (state)
        S_RWAIT: begin
          if (M_RVALID) begin
            rsp_rdata <= M_RDATA;
            rsp_err   <= (M_RRESP != RESP_OKAY);
          end else if (tmo_expired) begin
            rsp_err <= 1'b1;
          end
        end
        S_BWAIT: begin
          if (M_BVALID) begin
            rsp_err <= (M_BRESP != RESP_OKAY);
          end else if (tmo_expired) begin
            rsp_err <= 1'b1;
          end
        end
        S_EBUSY: begin
          if (M_AWREADY && tmo_expired) begin
            rsp_err <= 1'b1;
          end
        end
        S_EDONE: begin
          if (!M_AWREADY && tmo_expired) begin
            rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_axil_master.sv
// Bench for flash_axil_master: the stimulus thread plays both the command source and
// the flash slave; expected responses go into a queue that an independent monitor
// drains whenever a response handshake occurs.
module tb_flash_axil_master;
  import flash_axil_pkg::*;

  localparam int BUSY_WAIT      = 16;
  localparam int TIMEOUT_CYCLES = 600;

  logic        ACLK   = 1'b0;
  logic        ARESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op    = 2'b00;
  logic [23:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] M_AWADDR;
  logic        M_AWVALID;
  logic [2:0]  M_AWPROT;
  logic        M_AWREADY = 1'b0;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        M_WVALID;
  logic        M_WREADY  = 1'b0;
  logic        M_BVALID  = 1'b0;
  logic [1:0]  M_BRESP   = 2'b00;
  logic        M_BREADY;
  logic [31:0] M_ARADDR;
  logic        M_ARVALID;
  logic [2:0]  M_ARPROT;
  logic        M_ARREADY = 1'b0;
  logic        M_RVALID  = 1'b0;
  logic [31:0] M_RDATA   = '0;
  logic [1:0]  M_RRESP   = 2'b00;
  logic        M_RREADY;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fails   = 0;
  bit   stall_rsp = 1'b0;

  flash_axil_master #(
    .BUSY_WAIT      (BUSY_WAIT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .M_AWADDR  (M_AWADDR),
    .M_AWVALID (M_AWVALID),
    .M_AWPROT  (M_AWPROT),
    .M_AWREADY (M_AWREADY),
    .M_WDATA   (M_WDATA),
    .M_WSTRB   (M_WSTRB),
    .M_WVALID  (M_WVALID),
    .M_WREADY  (M_WREADY),
    .M_BVALID  (M_BVALID),
    .M_BRESP   (M_BRESP),
    .M_BREADY  (M_BREADY),
    .M_ARADDR  (M_ARADDR),
    .M_ARVALID (M_ARVALID),
    .M_ARPROT  (M_ARPROT),
    .M_ARREADY (M_ARREADY),
    .M_RVALID  (M_RVALID),
    .M_RDATA   (M_RDATA),
    .M_RRESP   (M_RRESP),
    .M_RREADY  (M_RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s: wait limit reached, required event not seen (t=%0t)", name, $time);
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  endtask

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Flash address as the slave expects it: op selector bit over the 24-bit byte address.
  function automatic logic [31:0] flash_addr(input op_e op, input logic [23:0] a);
    case (op)
      OP_READ, OP_WRITE: return 32'h0100_0000 + {8'h00, a};
      OP_ERASE_A:        return 32'h0200_0000 + {8'h00, a};
      default:           return 32'h0400_0000 + {8'h00, a};
    endcase
  endfunction

  task automatic issue_req(input op_e op, input logic [23:0] addr, input logic [31:0] wdata);
    int n = 0;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && n < 3 * TIMEOUT_CYCLES + 200) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      fail_now("req_ready_wait");
      finish_test();
    end
    tick();
    req_valid = 1'b0;
    req_op    = 2'($urandom_range(0, 3));
    req_addr  = 24'($urandom);
    req_wdata = $urandom;
  endtask

  // r_at: index (1-based) of the RREADY cycle in which RVALID is presented; 0 = never.
  task automatic run_read(input logic [23:0] addr, input int ar_delay, input int r_at,
                          input logic [31:0] data, input logic [1:0] resp);
    rsp_t e;
    int   k = 0;
    bit   ok;
    ok      = (r_at >= 1) && (r_at <= TIMEOUT_CYCLES);
    e.rdata = ok ? data : 32'h0;
    e.err   = ok ? (resp != 2'b00) : 1'b1;
    exp_q.push_back(e);
    issue_req(OP_READ, addr, $urandom);
    check("arvalid_rise", {31'h0, M_ARVALID}, 32'h1);
    check("araddr", M_ARADDR, flash_addr(OP_READ, addr));
    check("arprot", {29'h0, M_ARPROT}, 32'h0);
    for (int i = 0; i < ar_delay; i++) begin
      M_BVALID = 1'b1;  // stray write response, must be ignored
      M_BRESP  = 2'b10;
      tick();
      check("arvalid_hold", {31'h0, M_ARVALID}, 32'h1);
      check("araddr_hold", M_ARADDR, flash_addr(OP_READ, addr));
    end
    M_BVALID  = 1'b0;
    M_BRESP   = 2'b00;
    M_ARREADY = 1'b1;
    tick();
    M_ARREADY = 1'b0;
    check("arvalid_drop", {31'h0, M_ARVALID}, 32'h0);
    for (int i = 0; i < TIMEOUT_CYCLES + 4 && M_RREADY; i++) begin
      k++;
      if (k == r_at) begin
        M_RVALID = 1'b1;
        M_RDATA  = data;
        M_RRESP  = resp;
      end
      tick();
      M_RVALID = 1'b0;
      M_RDATA  = $urandom;
      M_RRESP  = 2'b00;
    end
    check("rready_cycles", k, ok ? r_at : TIMEOUT_CYCLES);
  endtask

  // Address/data phase shared by write and erase: one ready at a time during the delay.
  task automatic aw_phase(input op_e op, input logic [23:0] addr, input logic [31:0] wdata,
                          input int aw_delay);
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    exp_wdata = (op == OP_WRITE) ? wdata : 32'h0;
    exp_wstrb = (op == OP_WRITE) ? 4'hF : 4'h0;
    check("awvalid_rise", {30'h0, M_AWVALID, M_WVALID}, 32'h3);
    check("awaddr", M_AWADDR, flash_addr(op, addr));
    check("wdata", M_WDATA, exp_wdata);
    check("wstrb", {28'h0, M_WSTRB}, {28'h0, exp_wstrb});
    for (int i = 0; i < aw_delay; i++) begin
      M_AWREADY = 1'($urandom_range(0, 1));
      M_WREADY  = ~M_AWREADY;
      M_RVALID  = 1'b1;  // stray read data, must be ignored
      M_RRESP   = 2'b10;
      tick();
      check("awwvalid_hold", {30'h0, M_AWVALID, M_WVALID}, 32'h3);
      check("awaddr_hold", M_AWADDR, flash_addr(op, addr));
    end
    M_RVALID  = 1'b0;
    M_RRESP   = 2'b00;
    M_AWREADY = 1'b1;
    M_WREADY  = 1'b1;
    tick();
    M_WREADY  = 1'b0;
    check("awwvalid_drop", {30'h0, M_AWVALID, M_WVALID}, 32'h0);
  endtask

  task automatic run_write(input logic [23:0] addr, input logic [31:0] data, input int aw_delay,
                           input int b_at, input logic [1:0] resp);
    rsp_t e;
    int   k = 0;
    bit   ok;
    ok      = (b_at >= 1) && (b_at <= TIMEOUT_CYCLES);
    e.rdata = 32'h0;
    e.err   = ok ? (resp != 2'b00) : 1'b1;
    exp_q.push_back(e);
    issue_req(OP_WRITE, addr, data);
    aw_phase(OP_WRITE, addr, data, aw_delay);
    M_AWREADY = 1'b0;
    for (int i = 0; i < TIMEOUT_CYCLES + 4 && M_BREADY; i++) begin
      k++;
      if (k == b_at) begin
        M_BVALID = 1'b1;
        M_BRESP  = resp;
      end
      tick();
      M_BVALID = 1'b0;
      M_BRESP  = 2'b00;
    end
    check("bready_cycles", k, ok ? b_at : TIMEOUT_CYCLES);
  endtask

  // drop_at: EBUSY cycles with AWREADY still high; busy_len (>=1): cycles AWREADY stays low.
  task automatic run_erase(input op_e op, input logic [23:0] addr, input int aw_delay,
                           input int drop_at, input int busy_len);
    rsp_t e;
    bit   bready_seen = 1'b0;
    e.rdata = 32'h0;
    e.err   = !((drop_at < BUSY_WAIT) && (busy_len <= TIMEOUT_CYCLES));
    exp_q.push_back(e);
    issue_req(op, addr, $urandom);
    aw_phase(op, addr, 32'h0, aw_delay);
    for (int j = 0; j < drop_at; j++) begin
      bready_seen |= M_BREADY;
      tick();
    end
    M_AWREADY = 1'b0;
    for (int j = 0; j < busy_len; j++) begin
      bready_seen |= M_BREADY;
      tick();
    end
    M_AWREADY = 1'b1;
    bready_seen |= M_BREADY;
    tick();
    bready_seen |= M_BREADY;
    check("erase_no_bready", {31'h0, bready_seen}, 32'h0);
  endtask

  // Response consumer: random backpressure unless a stall is requested.
  initial begin : rsp_driver
    forever begin
      @(posedge ACLK);
      #1;
      rsp_ready = stall_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares each response handshake against the scoreboard, checks hold behaviour.
  initial begin : monitor
    bit          held = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_err  = 1'b0;
    rsp_t        e;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("rsp_valid_held", {31'h0, rsp_valid}, 32'h1);
          check("rsp_rdata_stable", rsp_rdata, held_data);
          check("rsp_err_stable", {31'h0, rsp_err}, {31'h0, held_err});
        end
        held = 1'b0;
        if (rsp_valid) begin
          check("req_ready_during_rsp", {31'h0, req_ready}, 32'h0);
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              fail_now("rsp_unexpected");
            end else begin
              e = exp_q.pop_front();
              check("rsp_rdata", rsp_rdata, e.rdata);
              check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
            end
          end else begin
            held      = 1'b1;
            held_data = rsp_rdata;
            held_err  = rsp_err;
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge ACLK);
    fail_now("watchdog");
    finish_test();
  end

  initial begin : stimulus
    op_e         op;
    logic [23:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat;
    int          n;

    // Reset state.
    repeat (3) tick();
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_valids", {27'h0, M_ARVALID, M_AWVALID, M_WVALID, M_RREADY, M_BREADY}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_addrs", M_ARADDR | M_AWADDR | M_WDATA, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    ARESET = 1'b0;
    tick();
    check("req_ready_after_rst", {31'h0, req_ready}, 32'h1);

    // Directed scenarios.
    run_read(24'h000100, 2, 40, 32'hDEADBEEF, 2'b00);
    run_write(24'h0000FC, 32'hA5A5_5A5A, 3, 1, 2'b00);
    run_erase(OP_ERASE_B, 24'h010000, 0, 2, 500);
    run_erase(OP_ERASE_A, 24'h000400, 1, BUSY_WAIT + 4, 1);
    run_erase(OP_ERASE_A, 24'h000800, 0, BUSY_WAIT - 1, 3);
    run_erase(OP_ERASE_B, 24'h000C00, 0, BUSY_WAIT, 3);
    run_read(24'h00ABCD, 0, 0, 32'h1111_2222, 2'b00);
    run_read(24'h00ABCE, 1, TIMEOUT_CYCLES, 32'h3333_4444, 2'b10);
    run_read(24'h00ABCF, 0, TIMEOUT_CYCLES + 1, 32'h5555_6666, 2'b00);
    run_write(24'h000200, 32'h0F0F_0F0F, 0, TIMEOUT_CYCLES, 2'b00);
    run_write(24'h000204, 32'h7777_8888, 2, 0, 2'b00);
    run_erase(OP_ERASE_A, 24'h001000, 0, 0, TIMEOUT_CYCLES);
    run_erase(OP_ERASE_B, 24'h002000, 0, 0, TIMEOUT_CYCLES + 1);

    // Response held by the consumer: fields stable, no new command accepted.
    stall_rsp = 1'b1;
    run_read(24'hABCDEF, 1, 3, 32'h1234_5678, 2'b00);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) fail_now("stall_rsp_wait");
    repeat (5) tick();
    check("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("stall_req_ready", {31'h0, req_ready}, 32'h0);
    stall_rsp = 1'b0;

    // Reset while the address/data phase is pending: no response may follow.
    M_AWREADY = 1'b0;
    M_WREADY  = 1'b0;
    issue_req(OP_WRITE, 24'h123456, 32'h0BAD_F00D);
    tick();
    check("midop_awwvalid", {30'h0, M_AWVALID, M_WVALID}, 32'h3);
    ARESET = 1'b1;
    tick();
    check("midop_rst_valids", {27'h0, M_ARVALID, M_AWVALID, M_WVALID, M_RREADY, M_BREADY}, 32'h0);
    check("midop_rst_req_rsp", {30'h0, req_ready, rsp_valid}, 32'h0);
    ARESET = 1'b0;
    tick();
    check("midop_req_ready", {31'h0, req_ready}, 32'h1);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      op   = op_e'($urandom_range(0, 3));
      addr = 24'($urandom);
      data = $urandom;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      lat  = ($urandom_range(0, 9) == 0) ? TIMEOUT_CYCLES + int'($urandom_range(0, 1))
                                         : int'($urandom_range(1, 8));
      case (op)
        OP_READ:  run_read(addr, $urandom_range(0, 4), lat, data, resp);
        OP_WRITE: run_write(addr, data, $urandom_range(0, 4), lat, resp);
        default:  run_erase(op, addr, $urandom_range(0, 4), $urandom_range(0, BUSY_WAIT),
                            $urandom_range(1, 30));
      endcase
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 32'h0);
    finish_test();
  end

endmodule
